// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of the RV32I core.
// Issues load/store requests on the dmem request/ready bus, waits up to
// TIMEOUT cycles for ready, extends load data and registers the MEM/WB slot.
// Optional build macro MEM_MISALIGN_CHK_EN adds misalign_o and retires
// misaligned halfword/word accesses without touching the bus.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] data2_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  regdst_i,
  input  logic        memrw_i,
  input  logic        regwen_i,
  input  logic [1:0]  wbsel_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        err_o,
  output logic        valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  regdst_o,
  output logic        regwen_o
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Request fields captured when an access has to wait
  logic [31:0] lat_alu, lat_data2, lat_pc;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_wbsel;
  logic [4:0]  lat_regdst;
  logic        lat_memrw, lat_regwen;

  // Fields of the access currently being served (live inputs in IDLE)
  logic [31:0] cur_alu, cur_data2, cur_pc;
  logic [2:0]  cur_funct3;
  logic [1:0]  cur_wbsel;
  logic [4:0]  cur_regdst;
  logic        cur_memrw, cur_regwen;

  logic        mem_op, misalign;
  logic        req, stall, complete, timeout, mis_ret, latch_en, req_out;
  logic [3:0]  be_val;
  logic [31:0] wdata_val, load_val, wb_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign mem_op = valid_i & (memrw_i | (wbsel_i == 2'b00));

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = ((funct3_i[1:0] == 2'b01) & alu_i[0]) |
                    ((funct3_i[1:0] == 2'b10) & (alu_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign cur_alu    = (state_reg == WAIT) ? lat_alu    : alu_i;
  assign cur_data2  = (state_reg == WAIT) ? lat_data2  : data2_i;
  assign cur_pc     = (state_reg == WAIT) ? lat_pc     : pc_i;
  assign cur_funct3 = (state_reg == WAIT) ? lat_funct3 : funct3_i;
  assign cur_wbsel  = (state_reg == WAIT) ? lat_wbsel  : wbsel_i;
  assign cur_regdst = (state_reg == WAIT) ? lat_regdst : regdst_i;
  assign cur_memrw  = (state_reg == WAIT) ? lat_memrw  : memrw_i;
  assign cur_regwen = (state_reg == WAIT) ? lat_regwen : regwen_i;

  // FSM state and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state, bus request, stall and retire decisions
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req        = 1'b0;
    stall      = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    mis_ret    = 1'b0;
    latch_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_i && !mem_op) begin
          complete = 1'b1;
        end else if (mem_op) begin
          if (misalign) begin
            mis_ret = 1'b1;
          end else begin
            req = 1'b1;
            if (dmem_ready_i) begin
              complete = 1'b1;
            end else begin
              stall      = 1'b1;
              latch_en   = 1'b1;
              cnt_next   = CNT_W'(1);
              state_next = WAIT;
            end
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (dmem_ready_i) begin
          complete   = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
          timeout    = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the request when it cannot complete in its first cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_alu    <= '0;
      lat_data2  <= '0;
      lat_pc     <= '0;
      lat_funct3 <= '0;
      lat_wbsel  <= '0;
      lat_regdst <= '0;
      lat_memrw  <= 1'b0;
      lat_regwen <= 1'b0;
    end else if (latch_en) begin
      lat_alu    <= alu_i;
      lat_data2  <= data2_i;
      lat_pc     <= pc_i;
      lat_funct3 <= funct3_i;
      lat_wbsel  <= wbsel_i;
      lat_regdst <= regdst_i;
      lat_memrw  <= memrw_i;
      lat_regwen <= regwen_i;
    end
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be_val    = 4'b1111;
    wdata_val = cur_data2;
    case (cur_funct3[1:0])
      2'b00: begin
        be_val    = 4'b0001 << cur_alu[1:0];
        wdata_val = {4{cur_data2[7:0]}};
      end
      2'b01: begin
        be_val    = cur_alu[1] ? 4'b1100 : 4'b0011;
        wdata_val = {2{cur_data2[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection, extension and write-back mux
  always_comb begin
    case (cur_alu[1:0])
      2'b00:   byte_sel = dmem_rdata_i[7:0];
      2'b01:   byte_sel = dmem_rdata_i[15:8];
      2'b10:   byte_sel = dmem_rdata_i[23:16];
      default: byte_sel = dmem_rdata_i[31:24];
    endcase
    half_sel = cur_alu[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (cur_funct3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = dmem_rdata_i;
    endcase
    case (cur_wbsel)
      2'b00:   wb_val = load_val;
      2'b01:   wb_val = cur_alu;
      2'b10:   wb_val = cur_pc + 32'd4;
      default: wb_val = 32'h0;
    endcase
  end

  // Bus outputs are forced low while reset is asserted
  assign req_out      = req & ~rst;
  assign dmem_req_o   = req_out;
  assign dmem_we_o    = req_out & cur_memrw;
  assign dmem_addr_o  = req_out ? {cur_alu[31:2], 2'b00} : 32'h0;
  assign dmem_be_o    = req_out ? be_val : 4'h0;
  assign dmem_wdata_o = req_out ? wdata_val : 32'h0;
  assign stall_o      = stall & ~rst;

  // MEM/WB pipeline register: retire, timeout retire or bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o   <= 1'b0;
      regwen_o  <= 1'b0;
      err_o     <= 1'b0;
      wb_data_o <= '0;
      regdst_o  <= '0;
    end else if (complete) begin
      valid_o   <= 1'b1;
      regwen_o  <= cur_regwen;
      err_o     <= 1'b0;
      wb_data_o <= wb_val;
      regdst_o  <= cur_regdst;
    end else if (timeout || mis_ret) begin
      valid_o  <= 1'b1;
      regwen_o <= 1'b0;
      err_o    <= timeout;
    end else begin
      valid_o  <= 1'b0;
      regwen_o <= 1'b0;
      err_o    <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  // One-cycle flag for a misaligned access retired without a bus cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_o <= 1'b0;
    else     misalign_o <= mis_ret;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven single-cycle accesses plus hand sequences for
// wait states, timeout and reset during a pending access.
module tb_mem_stage;

  logic        clk, rst;
  logic        valid_i, memrw_i, regwen_i, dmem_ready_i;
  logic [31:0] pc_i, alu_i, data2_i, dmem_rdata_i;
  logic [2:0]  funct3_i;
  logic [4:0]  regdst_i;
  logic [1:0]  wbsel_i;
  logic        dmem_req_o, dmem_we_o, stall_o, err_o, valid_o, regwen_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [3:0]  dmem_be_o;
  logic [4:0]  regdst_o;
`ifdef MEM_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .alu_i(alu_i),
    .data2_i(data2_i), .funct3_i(funct3_i), .regdst_i(regdst_i),
    .memrw_i(memrw_i), .regwen_i(regwen_i), .wbsel_i(wbsel_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .err_o(err_o), .valid_o(valid_o),
    .wb_data_o(wb_data_o), .regdst_o(regdst_o), .regwen_o(regwen_o)
`ifdef MEM_MISALIGN_CHK_EN
    , .misalign_o(misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] alu, data2, pc, rdata;
    logic        memrw;
    logic [1:0]  wbsel;
    logic        regwen;
    logic [4:0]  rd;
    logic        exp_req, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_wb;
    logic        exp_regwen;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] d2,
                        input logic [31:0] pc, input logic mrw, input logic [1:0] wbs,
                        input logic rwen, input logic [4:0] rd);
    funct3_i = f3; alu_i = alu; data2_i = d2; pc_i = pc;
    memrw_i = mrw; wbsel_i = wbs; regwen_i = rwen; regdst_i = rd;
    valid_i = 1'b1;
  endtask

  initial begin
    //              name        f3    alu           data2         pc            rdata         mrw   wbs    rwen  rd    req   we    be       addr          wdata         wb            rwen
    vecs[0]  = '{"lw",       3'd2, 32'h100,      32'h11223344, 32'h40,       32'hDEADBEEF, 1'b0, 2'd0, 1'b1, 5'd5,  1'b1, 1'b0, 4'b1111, 32'h100, 32'h11223344, 32'hDEADBEEF, 1'b1};
    vecs[1]  = '{"lb_neg",   3'd0, 32'h103,      32'h12,       32'h44,       32'h80FFFFFF, 1'b0, 2'd0, 1'b1, 5'd6,  1'b1, 1'b0, 4'b1000, 32'h100, 32'h12121212, 32'hFFFFFF80, 1'b1};
    vecs[2]  = '{"lbu",      3'd4, 32'h103,      32'h12,       32'h48,       32'h80FFFFFF, 1'b0, 2'd0, 1'b1, 5'd7,  1'b1, 1'b0, 4'b1000, 32'h100, 32'h12121212, 32'h00000080, 1'b1};
    vecs[3]  = '{"lhu",      3'd5, 32'h102,      32'h12345678, 32'h4C,       32'h80FFFFFF, 1'b0, 2'd0, 1'b1, 5'd8,  1'b1, 1'b0, 4'b1100, 32'h100, 32'h56785678, 32'h000080FF, 1'b1};
    vecs[4]  = '{"lh_lo",    3'd1, 32'h100,      32'h0,        32'h50,       32'h7FFF8000, 1'b0, 2'd0, 1'b1, 5'd9,  1'b1, 1'b0, 4'b0011, 32'h100, 32'h0,        32'hFFFF8000, 1'b1};
    vecs[5]  = '{"lh_hi",    3'd1, 32'h102,      32'h0,        32'h54,       32'h7FFF8000, 1'b0, 2'd0, 1'b1, 5'd10, 1'b1, 1'b0, 4'b1100, 32'h100, 32'h0,        32'h00007FFF, 1'b1};
    vecs[6]  = '{"lb_b1",    3'd0, 32'h101,      32'h0,        32'h58,       32'h00007F00, 1'b0, 2'd0, 1'b1, 5'd11, 1'b1, 1'b0, 4'b0010, 32'h100, 32'h0,        32'h0000007F, 1'b1};
    vecs[7]  = '{"sw",       3'd2, 32'h204,      32'hCAFEBABE, 32'h5C,       32'h0,        1'b1, 2'd0, 1'b0, 5'd0,  1'b1, 1'b1, 4'b1111, 32'h204, 32'hCAFEBABE, 32'h0,        1'b0};
    vecs[8]  = '{"sh",       3'd1, 32'h212,      32'h0000BEEF, 32'h60,       32'h0,        1'b1, 2'd0, 1'b0, 5'd0,  1'b1, 1'b1, 4'b1100, 32'h210, 32'hBEEFBEEF, 32'h0,        1'b0};
    vecs[9]  = '{"pc4_wrap", 3'd0, 32'h55,       32'h0,        32'hFFFFFFFC, 32'h0,        1'b0, 2'd2, 1'b1, 5'd1,  1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h00000000, 1'b1};
    vecs[10] = '{"pc4",      3'd0, 32'h55,       32'h0,        32'h100,      32'h0,        1'b0, 2'd2, 1'b1, 5'd1,  1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h00000104, 1'b1};
    vecs[11] = '{"zero",     3'd0, 32'hFFFF,     32'h0,        32'h64,       32'h0,        1'b0, 2'd3, 1'b1, 5'd3,  1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h00000000, 1'b1};
    vecs[12] = '{"alu",      3'd0, 32'h12345678, 32'h0,        32'h68,       32'hFFFFFFFF, 1'b0, 2'd1, 1'b1, 5'd12, 1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h12345678, 1'b1};

    // Reset with a pending-looking load on the inputs: everything must read 0
    rst = 1'b1; dmem_ready_i = 1'b0; dmem_rdata_i = 32'h0;
    set_op(3'd2, 32'h100, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1, 5'd5);
    @(posedge clk); #1;
    check("rst_req", {31'h0, dmem_req_o}, 32'h0);
    check("rst_stall", {31'h0, stall_o}, 32'h0);
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_regwen", {31'h0, regwen_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    check("rst_wb", wb_data_o, 32'h0);
    check("rst_rd", {27'h0, regdst_o}, 32'h0);
    check("rst_addr", dmem_addr_o, 32'h0);
    $display("reset state checked");
    @(negedge clk); rst = 1'b0; valid_i = 1'b0;

    // Single-cycle transactions (ready in the request cycle)
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      set_op(vecs[i].f3, vecs[i].alu, vecs[i].data2, vecs[i].pc, vecs[i].memrw,
             vecs[i].wbsel, vecs[i].regwen, vecs[i].rd);
      dmem_ready_i = 1'b1; dmem_rdata_i = vecs[i].rdata;
      #1;
      check({vecs[i].name, "_req"}, {31'h0, dmem_req_o}, {31'h0, vecs[i].exp_req});
      check({vecs[i].name, "_we"}, {31'h0, dmem_we_o}, {31'h0, vecs[i].exp_we});
      check({vecs[i].name, "_be"}, {28'h0, dmem_be_o}, {28'h0, vecs[i].exp_be});
      check({vecs[i].name, "_addr"}, dmem_addr_o, vecs[i].exp_addr);
      check({vecs[i].name, "_wdata"}, dmem_wdata_o, vecs[i].exp_wdata);
      check({vecs[i].name, "_stall"}, {31'h0, stall_o}, 32'h0);
      @(posedge clk); #1;
      check({vecs[i].name, "_valid"}, {31'h0, valid_o}, 32'h1);
      check({vecs[i].name, "_wb"}, wb_data_o, vecs[i].exp_wb);
      check({vecs[i].name, "_regwen"}, {31'h0, regwen_o}, {31'h0, vecs[i].exp_regwen});
      check({vecs[i].name, "_rd"}, {27'h0, regdst_o}, {27'h0, vecs[i].rd});
      check({vecs[i].name, "_err"}, {31'h0, err_o}, 32'h0);
      valid_i = 1'b0;
      $display("vector %s: wb_data=0x%08h", vecs[i].name, wb_data_o);
    end

    // Bubble: valid drops, data and regdst hold
    @(posedge clk); #1;
    check("bubble_valid", {31'h0, valid_o}, 32'h0);
    check("bubble_wb_hold", wb_data_o, 32'h12345678);
    check("bubble_rd_hold", {27'h0, regdst_o}, 32'd12);
    $display("bubble checked");

    // SB with three stall cycles before ready
    @(negedge clk);
    set_op(3'd0, 32'h101, 32'h000000AB, 32'h80, 1'b1, 2'd0, 1'b0, 5'd0);
    dmem_ready_i = 1'b0; dmem_rdata_i = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("sb_stall", {31'h0, stall_o}, 32'h1);
      check("sb_req", {31'h0, dmem_req_o}, 32'h1);
      check("sb_we", {31'h0, dmem_we_o}, 32'h1);
      check("sb_be", {28'h0, dmem_be_o}, 32'h2);
      check("sb_wdata", dmem_wdata_o, 32'hABABABAB);
      check("sb_addr", dmem_addr_o, 32'h100);
      @(posedge clk); #1;
      check("sb_bubble", {31'h0, valid_o}, 32'h0);
      @(negedge clk);
    end
    dmem_ready_i = 1'b1; #1;
    check("sb_done_stall", {31'h0, stall_o}, 32'h0);
    check("sb_done_req", {31'h0, dmem_req_o}, 32'h1);
    @(posedge clk); #1;
    check("sb_valid", {31'h0, valid_o}, 32'h1);
    check("sb_regwen", {31'h0, regwen_o}, 32'h0);
    valid_i = 1'b0;
    $display("sb with wait states done");

    // LW that never gets ready: timeout after 4 wait cycles
    @(negedge clk);
    set_op(3'd2, 32'h300, 32'h0, 32'h90, 1'b0, 2'd0, 1'b1, 5'd4);
    dmem_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("to_stall", {31'h0, stall_o}, 32'h1);
      check("to_req", {31'h0, dmem_req_o}, 32'h1);
      @(posedge clk); #1;
      check("to_bubble", {31'h0, valid_o}, 32'h0);
      check("to_err_early", {31'h0, err_o}, 32'h0);
      @(negedge clk);
    end
    #1;
    check("to_last_stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    check("to_valid", {31'h0, valid_o}, 32'h1);
    check("to_regwen", {31'h0, regwen_o}, 32'h0);
    check("to_err", {31'h0, err_o}, 32'h1);
    valid_i = 1'b0; #1;
    check("to_req_drop", {31'h0, dmem_req_o}, 32'h0);
    @(posedge clk); #1;
    check("to_err_pulse", {31'h0, err_o}, 32'h0);
    check("to_after_valid", {31'h0, valid_o}, 32'h0);
    $display("timeout sequence done");

    // Reset in the second wait cycle, then a clean LW
    @(negedge clk);
    set_op(3'd2, 32'h400, 32'h0, 32'hA0, 1'b0, 2'd0, 1'b1, 5'd9);
    dmem_ready_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; #1;
    check("rw_req", {31'h0, dmem_req_o}, 32'h0);
    check("rw_stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    check("rw_valid", {31'h0, valid_o}, 32'h0);
    check("rw_regwen", {31'h0, regwen_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    set_op(3'd2, 32'h500, 32'h0, 32'hB0, 1'b0, 2'd0, 1'b1, 5'd14);
    dmem_ready_i = 1'b1; dmem_rdata_i = 32'h13579BDF; #1;
    check("rw_lw_req", {31'h0, dmem_req_o}, 32'h1);
    check("rw_lw_addr", dmem_addr_o, 32'h500);
    check("rw_lw_stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    check("rw_lw_valid", {31'h0, valid_o}, 32'h1);
    check("rw_lw_wb", wb_data_o, 32'h13579BDF);
    check("rw_lw_regwen", {31'h0, regwen_o}, 32'h1);
    check("rw_lw_rd", {27'h0, regdst_o}, 32'd14);
    valid_i = 1'b0;
    $display("reset during wait sequence done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
